instr_loader: RTL
=================

# instr_loader

Boot-time program loader: the write-side counterpart to the Processor's instruction fetch. Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into the 128-entry instruction memory addressed by the 7-bit PC. Holds the Processor in reset until a complete, well-formed frame has been written.

## Interface
Parameters:
- ADDR_W, 7, instruction memory address width; matches PC_Out.
- WORD_W, 16, instruction width; matches IR_Out.
- HDR_BYTE, 8'hA5, frame start byte.

Ports:
- Clk  input  1  system clock, rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- In_Valid  input  1  source has a byte on In_Data.
- In_Data  input  8  stream byte.
- In_Ready  output  1  loader accepts In_Data this cycle; a byte transfers when In_Valid && In_Ready.
- IM_Wr  output  1  one-cycle instruction memory write strobe.
- IM_Addr  output  ADDR_W  write address.
- IM_WData  output  WORD_W  write data.
- CPU_ResetN  output  1  active-low reset to Processor; low until load succeeds.
- Busy  output  1  frame in progress (LEN through CHK).
- Done  output  1  frame loaded successfully; sticky.
- Error  output  1  frame rejected; sticky until next HDR_BYTE or reset.
- Word_Count  output  ADDR_W+1  words written in the current frame.

## Operation
- Frame: HDR_BYTE, length N (1..128), N words sent high byte then low byte, then checksum byte when LOADER_CHECKSUM_EN is defined.
- States: IDLE, LEN, HI, LO, CHK, DONE, ERR.
- IDLE: In_Ready=1. HDR_BYTE -> LEN. Any other byte is discarded.
- LEN: N=0 or N>128 -> ERR. Otherwise latch N, clear word index and checksum, -> HI.
- HI: latch byte as word[15:8] -> LO.
- LO: register {hi,lo} to IM_WData and index to IM_Addr, pulse IM_Wr next cycle, increment index. If index+1==N -> CHK (macro defined) or DONE (macro undefined). Otherwise -> HI.
- CHK: byte == XOR of all 2N data bytes -> DONE. Mismatch -> ERR.
- DONE: In_Ready=0, Done=1, CPU_ResetN=1. The loader leaves DONE only on reset.
- ERR: Error=1, CPU_ResetN=0, In_Ready=1. HDR_BYTE clears Error and -> LEN. Other bytes are discarded. Words already written stay in memory; the next frame overwrites them.
- Index arithmetic is ADDR_W+1 bits, so N=128 is reachable and the last address is 127 with no wrap.

## Timing
- Reset values:
  - State=IDLE, In_Ready=0 during reset and 1 on the first cycle after release.
  - IM_Wr=0, IM_Addr=0, IM_WData=0.
  - CPU_ResetN=0, Busy=0, Done=0, Error=0, Word_Count=0.
- Throughput: one byte per cycle, with no stall on write cycles.
- IM_Wr is asserted exactly one cycle after the LO byte transfer. Word_Count updates on that same cycle.
- CPU_ResetN rises one cycle after DONE is entered. It is registered, so it never glitches.
- Done and Busy are registered decodes of the state.
- In_Valid low is an idle cycle: no state change, no counter change.
- ResetN assertion mid-frame aborts immediately. All outputs take their reset values asynchronously, and a pending IM_Wr is dropped.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHK state and the XOR accumulator are compiled in.
  - The frame carries a trailing checksum byte, and a mismatch goes to ERR.
- LOADER_CHECKSUM_EN undefined:
  - No CHK state and no checksum byte.
  - LO goes directly to DONE after the Nth word.
  - ERR is reachable only via an invalid length.

## Structure
- Shared package loader_pkg:
  - state enum loader_state_t;
  - HDR_BYTE and MAX_WORDS=128 constants;
  - ADDR_W and WORD_W localparams shared with ControlUnit.
- One sub-module, loader_chk: XOR accumulator with clear and enable inputs and an 8-bit output. It is instantiated only under LOADER_CHECKSUM_EN.

## Test plan
- Reset release, then A5 02 12 34 AB CD plus checksum 8'h40 -> IM_Wr writes 0x1234@0 and 0xABCD@1, Done=1, CPU_ResetN rises one cycle after DONE.
- Same frame with checksum 8'h41 -> Error=1, CPU_ResetN stays 0. A following good frame clears Error and ends with Done=1.
- Garbage bytes 00 FF 5A before A5 01 BE EF plus checksum 8'h51 -> garbage ignored, single write 0xBEEF@0.
- Length byte 00, and separately 8'h81 -> ERR with no IM_Wr. Length 8'h80 with 128 words -> last write at address 127, Word_Count=128.
- Random In_Valid gaps, plus ResetN pulsed low after 3 of 5 words -> no extra writes. After reset, a fresh frame loads correctly.
- With LOADER_CHECKSUM_EN undefined: A5 01 12 34 -> Done=1 the cycle after the write, with no checksum byte consumed.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;
  localparam int ADDR_W    = 7;
  localparam int WORD_W    = 16;
  localparam int MAX_WORDS = 128;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_CHK, S_DONE, S_ERR
  } loader_state_t;
endpackage

// File: rtl/loader_chk.sv
// Running XOR of frame data bytes; only built when LOADER_CHECKSUM_EN is defined.
module loader_chk (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);
  logic [7:0] sum_q;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)    sum_q <= '0;
    else if (clr_i) sum_q <= '0;
    else if (en_i)  sum_q <= sum_q ^ data_i;
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/instr_loader.sv
// Byte-stream program loader: assembles 16-bit words into instruction memory and
// holds the CPU in reset until a full frame lands. Macro: LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int         ADDR_W   = loader_pkg::ADDR_W,
  parameter int         WORD_W   = loader_pkg::WORD_W,
  parameter logic [7:0] HDR_BYTE = loader_pkg::HDR_BYTE
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              In_Valid,
  input  logic [7:0]        In_Data,
  output logic              In_Ready,
  output logic              IM_Wr,
  output logic [ADDR_W-1:0] IM_Addr,
  output logic [WORD_W-1:0] IM_WData,
  output logic              CPU_ResetN,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   Word_Count
);
  import loader_pkg::*;

  localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d, idx_q, idx_d, wcnt_q, wcnt_d, idx_inc;
  logic [7:0]        hi_q, hi_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              rdy_q, done_q, busy_q, err_q;
  logic              xfer;

  assign xfer    = In_Valid && In_Ready;
  assign idx_inc = idx_q + (ADDR_W+1)'(1);

`ifdef LOADER_CHECKSUM_EN
  logic       chk_clr, chk_en;
  logic [7:0] chk_sum;

  loader_chk u_chk (
    .Clk   (Clk),
    .ResetN(ResetN),
    .clr_i (chk_clr),
    .en_i  (chk_en),
    .data_i(In_Data),
    .sum_o (chk_sum)
  );
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    hi_d    = hi_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    chk_clr = 1'b0;
    chk_en  = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_ERR: if (xfer && In_Data == HDR_BYTE) state_d = S_LEN;
      S_LEN: if (xfer) begin
        if (In_Data == 8'd0 || In_Data > MAX_LEN) begin
          state_d = S_ERR;
        end else begin
          n_d     = (ADDR_W+1)'(In_Data);
          idx_d   = '0;
          wcnt_d  = '0;
          state_d = S_HI;
`ifdef LOADER_CHECKSUM_EN
          chk_clr = 1'b1;
`endif
        end
      end
      S_HI: if (xfer) begin
        hi_d    = In_Data;
        state_d = S_LO;
`ifdef LOADER_CHECKSUM_EN
        chk_en  = 1'b1;
`endif
      end
      // The write is registered here so IM_Wr pulses the cycle after the LO byte.
      S_LO: if (xfer) begin
        wdata_d = WORD_W'({hi_q, In_Data});
        addr_d  = idx_q[ADDR_W-1:0];
        wr_d    = 1'b1;
        idx_d   = idx_inc;
        wcnt_d  = idx_inc;
`ifdef LOADER_CHECKSUM_EN
        chk_en  = 1'b1;
        state_d = (idx_inc == n_q) ? S_CHK : S_HI;
`else
        state_d = (idx_inc == n_q) ? S_DONE : S_HI;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (xfer) state_d = (In_Data == chk_sum) ? S_DONE : S_ERR;
`endif
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      hi_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      hi_q    <= hi_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= (state_d != S_DONE);
      done_q  <= (state_q == S_DONE);
      busy_q  <= (state_q inside {S_LEN, S_HI, S_LO, S_CHK});
      err_q   <= (state_q == S_ERR);
    end
  end

  assign In_Ready   = rdy_q;
  assign IM_Wr      = wr_q;
  assign IM_Addr    = addr_q;
  assign IM_WData   = wdata_q;
  assign CPU_ResetN = done_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Error      = err_q;
  assign Word_Count = wcnt_q;
endmodule
